// File: rtl/encoder_pkg.sv
// Shared 64b/66b definitions for the 10GBASE-R encode/decode path.
package encoder_pkg;

  // Legal 2-bit sync header values
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTL  = 2'b10;

  // Receive block-lock controller states
  typedef enum logic {
    TEST_SH   = 1'b0,
    SLIP_WAIT = 1'b1
  } lock_state_t;

  // A header is valid only when its two bits differ in one of the two legal ways
  function automatic logic is_sync_header(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// Receive block-lock controller: tracks sync headers of valid 66-bit blocks,
// asserts block lock after a clean window and commands single-block gearbox
// slips while searching for (or after losing) alignment.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// TEST_SH   | sampling headers on valid cycles, counting window/invalids
// SLIP_WAIT | slip issued; ignore input while the gearbox realigns
module rx_block_lock
  import encoder_pkg::*;
#(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input  logic        i_rxc,
  input  logic        i_reset,
  input  logic        i_init_done,
  input  logic [1:0]  i_rx_header,
  input  logic        i_rx_valid,
  output logic        o_slip,
  output logic        o_block_lock,
  output logic [15:0] o_slip_count
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_MAX  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(SLIP_WAIT_CYCLES);

  lock_state_t       state, state_n;
  logic [CNT_W-1:0]  sh_cnt, sh_cnt_n;
  logic [INV_W-1:0]  sh_invld_cnt, sh_invld_cnt_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic              slip_n;
  logic              lock_n;
  logic [15:0]       slip_count_n;

  logic              sh_valid;
  logic [CNT_W-1:0]  cnt_inc;
  logic [INV_W-1:0]  invld_inc;
  logic              lose_lock;

  // Per-sample arithmetic shared by all TEST_SH rules
  always_comb begin
    sh_valid  = is_sync_header(i_rx_header);
    cnt_inc   = sh_cnt + 1'b1;
    invld_inc = sh_invld_cnt + INV_W'(!sh_valid);
    // Unlocked: any bad header slips. Locked: only the window's last allowed one.
    lose_lock = !sh_valid && (!o_block_lock || (invld_inc == INV_MAX));
  end

  // Next-state and next-output logic
  always_comb begin
    state_n        = state;
    sh_cnt_n       = sh_cnt;
    sh_invld_cnt_n = sh_invld_cnt;
    wait_cnt_n     = wait_cnt;
    slip_n         = 1'b0;
    lock_n         = o_block_lock;
    slip_count_n   = o_slip_count;

    case (state)
      TEST_SH: begin
        if (i_rx_valid) begin
          if (lose_lock) begin
            lock_n         = 1'b0;
            slip_n         = 1'b1;
            slip_count_n   = (o_slip_count == 16'hFFFF) ? o_slip_count
                                                        : o_slip_count + 16'd1;
            sh_cnt_n       = '0;
            sh_invld_cnt_n = '0;
            wait_cnt_n     = WAIT_LD;
            state_n        = SLIP_WAIT;
          end else if (cnt_inc == CNT_MAX) begin
            // Window complete: a clean window grants lock, a dirty one keeps it as-is
            if (invld_inc == '0) begin
              lock_n = 1'b1;
            end
            sh_cnt_n       = '0;
            sh_invld_cnt_n = '0;
          end else begin
            sh_cnt_n       = cnt_inc;
            sh_invld_cnt_n = invld_inc;
          end
        end
      end

      SLIP_WAIT: begin
        // Down-counter: loaded with the hold-off length, leaves at terminal count
        if (wait_cnt == '0) begin
          state_n        = TEST_SH;
          sh_cnt_n       = '0;
          sh_invld_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt - 1'b1;
        end
      end

      default: begin
        state_n = TEST_SH;
      end
    endcase
  end

  // State and output registers; init_done low clears everything except the slip tally
  always_ff @(posedge i_rxc) begin
    if (i_reset) begin
      state        <= TEST_SH;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_slip_count <= 16'd0;
    end else if (!i_init_done) begin
      state        <= TEST_SH;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
    end else begin
      state        <= state_n;
      sh_cnt       <= sh_cnt_n;
      sh_invld_cnt <= sh_invld_cnt_n;
      wait_cnt     <= wait_cnt_n;
      o_slip       <= slip_n;
      o_block_lock <= lock_n;
      o_slip_count <= slip_count_n;
    end
  end

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Receive block-lock controller for the 10GBASE-R receive path. It sits between the transceiver gearbox and the 64b/66b decoder. It watches the 2-bit sync header of every valid 66-bit block and implements the Clause 49 lock procedure. While unlocked or losing lock, it commands single-block bit slips on the gearbox. Its lock output is the qualifier the decoder and downstream MAC use as "receive path initialised".

## Interface
- SH_CNT_MAX, 64: valid-sample window length in headers.
- SH_INVALID_MAX, 16: invalid headers within one window that force loss of lock.
- SLIP_WAIT_CYCLES, 32: cycles to hold off after a slip pulse while the gearbox realigns; must be ≥1.
- i_rxc  in  1  receive block clock; all logic on its rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_init_done  in  1  transceiver reset sequence complete; low acts as a soft reset.
- i_rx_header  in  2  sync header of the current block.
- i_rx_valid  in  1  header/data valid this cycle; gearbox gaps deassert it.
- o_slip  out  1  one-cycle slip request to the gearbox.
- o_block_lock  out  1  block lock achieved; drives the decoder init-done input.
- o_slip_count  out  16  slips issued since reset; saturates at 16'hFFFF.

## Operation
- sh_valid = (i_rx_header == SYNC_DATA) || (i_rx_header == SYNC_CTL), i.e. 2'b01 or 2'b10.
- A sample is a cycle in TEST_SH with i_rx_valid = 1. Only samples count.
- Internal counters:
  - sh_cnt: width $clog2(SH_CNT_MAX+1).
  - sh_invld_cnt: width $clog2(SH_INVALID_MAX+1).
- States: TEST_SH and SLIP_WAIT.
- On each sample, compute cnt_n = sh_cnt+1 and invld_n = sh_invld_cnt + !sh_valid, then apply the first matching rule:
  1. !sh_valid and (!o_block_lock or invld_n == SH_INVALID_MAX): o_block_lock ← 0, pulse o_slip, increment o_slip_count (saturating), clear both counters, go to SLIP_WAIT.
  2. cnt_n == SH_CNT_MAX: if invld_n == 0 then o_block_lock ← 1, otherwise lock is unchanged. Clear both counters and stay in TEST_SH.
  3. Otherwise: sh_cnt ← cnt_n, sh_invld_cnt ← invld_n.
- Consequences of these rules:
  - Unlocked: any single invalid header slips immediately.
  - Locked: a window with 1..SH_INVALID_MAX-1 invalid headers keeps the lock. Lock is dropped at the SH_INVALID_MAX-th invalid header, without waiting for the window to end.
- SLIP_WAIT:
  - A wait counter runs SLIP_WAIT_CYCLES cycles, then returns to TEST_SH with counters zero.
  - i_rx_valid and i_rx_header are ignored throughout.
- Control priority, highest first:
  1. i_reset: everything goes to reset values, o_slip_count included.
  2. !i_init_done: state, counters, o_slip and o_block_lock are cleared. o_slip_count is retained.
  3. Normal operation. Either clear aborts SLIP_WAIT mid-count.

## Timing
- All outputs are registered. Reset values: o_slip = 0, o_block_lock = 0, o_slip_count = 0, state TEST_SH, all counters 0.
- o_slip is high for exactly the one cycle after the offending sample. Slip pulses are spaced at least SLIP_WAIT_CYCLES+1 cycles apart.
- o_block_lock rises the cycle after the SH_CNT_MAX-th clean sample, so minimum lock latency is SH_CNT_MAX+1 cycles from leaving reset with continuous valid.
- o_block_lock falls the cycle after the lock-losing sample, in the same cycle o_slip asserts.
- The first post-slip sample is taken SLIP_WAIT_CYCLES+1 cycles after o_slip asserts.
- Samples are counted only with i_rx_valid high, so latencies stretch with gearbox gaps. Window boundaries are counted in samples, not cycles.

## Structure
- Add lock_state_t {TEST_SH, SLIP_WAIT} to encoder_pkg.
- SYNC_DATA / SYNC_CTL are taken from encoder_pkg; no local header constants.
- Single flat module, no sub-module. The saturating slip counter is inline logic.

## Test plan
Defaults are used throughout: SH_CNT_MAX 64, SH_INVALID_MAX 16, SLIP_WAIT_CYCLES 32.
- Reset, then 64 continuous samples of header 2'b01 -> o_block_lock = 1 on cycle 65; o_slip never asserts; o_slip_count = 0.
- Unlocked, header 2'b00 on the 10th sample -> o_slip one-cycle pulse on the next cycle; o_slip_count = 1. Headers 2'b11 in the following 32 cycles are ignored (no second slip). Then 64 samples of 2'b10 -> lock.
- Locked, window of 64 samples with 15 headers of 2'b11 -> lock held, no slip. In the next window, the 16th invalid header -> o_block_lock = 0 and o_slip = 1 the following cycle, mid-window.
- Locked, window with 1 invalid header, then a clean window -> o_block_lock stays 1 throughout, with no slip.
- i_rx_valid toggling every cycle, with 2'b11 on invalid cycles only -> no slip; lock after 64 valid samples (~128 cycles).
- i_reset asserted 5 cycles into SLIP_WAIT after 3 slips -> next cycle all outputs 0, o_slip_count = 0. Repeated with i_init_done low instead -> o_slip_count stays 3, lock 0, no slip.
